// File: rtl/text_pkg.sv
// Shared constants and types for the text-rectangle character buffer.
package text_pkg;

  localparam int TEXT_ADDR_W = 8;
  localparam int TEXT_CHAR_W = 7;
  localparam logic [TEXT_CHAR_W-1:0] TEXT_BLANK_CHAR = 7'h20;

  typedef enum logic [1:0] {
    INIT_CLR,
    IDLE,
    CLEAR
  } char_buf_state_t;

endpackage

// File: rtl/char_buf_ram.sv
// Character-code storage: one registered read port, one write port, read-first.
module char_buf_ram
  import text_pkg::*;
#(
  parameter int ADDR_W = TEXT_ADDR_W,
  parameter int CHAR_W = TEXT_CHAR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [CHAR_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [CHAR_W-1:0] rdata
);

  logic [CHAR_W-1:0] mem [2**ADDR_W];

  // No reset so synthesis can map this onto block or distributed RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/char_buf_ctrl.sv
// Character buffer controller: serves renderer reads every cycle and commits
// single-character writes and full clears only while vertical blanking is active.
module char_buf_ctrl
  import text_pkg::*;
#(
  parameter int                ADDR_W     = TEXT_ADDR_W,
  parameter int                CHAR_W     = TEXT_CHAR_W,
  parameter logic [CHAR_W-1:0] BLANK_CHAR = TEXT_BLANK_CHAR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vblnk,
  input  logic [ADDR_W-1:0] char_xy,
  output logic [CHAR_W-1:0] char_code,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CHAR_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              clr_req,
  output logic              clr_done,
  output logic              busy
);

  char_buf_state_t   state;
  logic [ADDR_W-1:0] cnt;
  logic              rd_valid;
  logic              accept_wr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [CHAR_W-1:0] mem_data;
  logic [CHAR_W-1:0] ram_rdata;

  // A write is taken only in IDLE, when no clear wants the buffer, and never in
  // the ack cycle, so a request held until its ack commits exactly once.
  assign accept_wr = (state == IDLE) && !clr_req && wr_req && vblnk && !wr_ack;

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = cnt;
    mem_data = BLANK_CHAR;
    case (state)
      INIT_CLR, CLEAR: mem_we = vblnk;
      IDLE: begin
        if (accept_wr) begin
          mem_we   = 1'b1;
          mem_addr = wr_addr;
          mem_data = wr_data;
        end
      end
      default: mem_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= INIT_CLR;
      cnt      <= '0;
      busy     <= 1'b1;
      wr_ack   <= 1'b0;
      clr_done <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      wr_ack   <= 1'b0;
      clr_done <= 1'b0;
      rd_valid <= 1'b1;
      case (state)
        INIT_CLR, CLEAR: begin
          if (vblnk) begin
            cnt <= cnt + 1'b1;
            if (cnt == {ADDR_W{1'b1}}) begin
              state    <= IDLE;
              busy     <= 1'b0;
              clr_done <= 1'b1;
            end
          end
        end
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end else if (accept_wr) begin
            wr_ack <= 1'b1;
          end
        end
        default: begin
          state <= INIT_CLR;
          cnt   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  char_buf_ram #(
    .ADDR_W(ADDR_W),
    .CHAR_W(CHAR_W)
  ) u_ram (
    .clk  (clk),
    .we   (mem_we),
    .waddr(mem_addr),
    .wdata(mem_data),
    .raddr(char_xy),
    .rdata(ram_rdata)
  );

  // The RAM read register is unreset; mask it so char_code reads 0 out of reset.
  assign char_code = rd_valid ? ram_rdata : '0;

endmodule

// File: tb/tb_char_buf_ctrl.sv
// Self-checking bench for char_buf_ctrl: read results are scoreboarded through
// a queue and compared one cycle after the address is driven.
module tb_char_buf_ctrl;

  logic       clk;
  logic       rst;
  logic       vblnk;
  logic [7:0] char_xy;
  logic [6:0] char_code;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [6:0] wr_data;
  logic       wr_ack;
  logic       clr_req;
  logic       clr_done;
  logic       busy;

  int         check_count = 0;
  int         error_count = 0;
  logic [6:0] model [256];
  logic [6:0] exp_q [$];

  char_buf_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .vblnk    (vblnk),
    .char_xy  (char_xy),
    .char_code(char_code),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .clr_req  (clr_req),
    .clr_done (clr_done),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] addr, input logic [6:0] data);
    wr_addr = addr;
    wr_data = data;
    wr_req  = 1'b1;
  endtask

  task automatic read_sweep(input int lo, input int hi);
    logic [6:0] exp;
    for (int a = lo; a <= hi; a++) begin
      char_xy = a[7:0];
      exp_q.push_back(model[a]);
      @(negedge clk);
      exp = exp_q.pop_front();
      checkOutput($sformatf("rd[%0h]", a), {25'd0, char_code}, {25'd0, exp});
    end
  endtask

  task automatic model_fill_blank();
    for (int a = 0; a < 256; a++) model[a] = 7'h20;
  endtask

  // Runs until clr_done, counting vblnk-high cycles seen by the DUT.
  task automatic wait_clear(input string tag, input bit toggle);
    int n_vb = 0;
    int n_busy_low = 0;
    int n_ack = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      if (toggle) vblnk = ((i / 10) % 2) == 0;
      if (vblnk) n_vb++;
      @(negedge clk);
      if (wr_ack) n_ack++;
      if (clr_done) seen = 1'b1;
      else if (!busy) n_busy_low++;
    end
    clr_req = 1'b0;
    vblnk   = 1'b1;
    checkOutput({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    checkOutput({tag, "_vblnk_cycles"}, n_vb, 32'd256);
    checkOutput({tag, "_busy_low_early"}, n_busy_low, 32'd0);
    checkOutput({tag, "_ack_during_clear"}, n_ack, 32'd0);
    checkOutput({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    int n_done = 0;
    int n_busy = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (clr_done) n_done++;
      if (busy) n_busy++;
    end
    checkOutput({tag, "_extra_done"}, n_done, 32'd0);
    checkOutput({tag, "_busy_after"}, n_busy, 32'd0);
  endtask

  task automatic do_write(input string tag, input logic [7:0] addr, input logic [6:0] data);
    bit got = 1'b0;
    applyStimulus(addr, data);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (wr_ack) got = 1'b1;
    end
    wr_req = 1'b0;
    checkOutput({tag, "_ack"}, {31'd0, got}, 32'd1);
    model[addr] = data;
  endtask

  initial begin
    int n_ack;
    rst     = 1'b0;
    vblnk   = 1'b1;
    char_xy = '0;
    wr_req  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    clr_req = 1'b0;

    // Test 1: reset values, then INIT_CLR with vblnk held high.
    repeat (3) @(negedge clk);
    checkOutput("rst_char_code", {25'd0, char_code}, 32'd0);
    checkOutput("rst_wr_ack", {31'd0, wr_ack}, 32'd0);
    checkOutput("rst_clr_done", {31'd0, clr_done}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    wait_clear("init", 1'b0);
    check_quiet("init", 5);
    model_fill_blank();
    read_sweep(0, 255);

    // Test 2: write stalls while vblnk is low, commits on the first high cycle.
    vblnk = 1'b0;
    applyStimulus(8'h12, 7'h41);
    n_ack = 0;
    repeat (50) begin
      @(negedge clk);
      if (wr_ack) n_ack++;
    end
    checkOutput("t2_no_ack_low_vblnk", n_ack, 32'd0);
    vblnk = 1'b1;
    @(negedge clk);
    checkOutput("t2_ack_latency", {31'd0, wr_ack}, 32'd1);
    wr_req = 1'b0;
    @(negedge clk);
    checkOutput("t2_ack_single", {31'd0, wr_ack}, 32'd0);
    model[8'h12] = 7'h41;
    read_sweep(8'h11, 8'h13);

    // Test 3: clear with vblnk toggling 10 on / 10 off.
    do_write("t3_pre", 8'hFF, 7'h7F);
    read_sweep(8'hFE, 8'hFF);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    checkOutput("t3_busy_start", {31'd0, busy}, 32'd1);
    wait_clear("t3", 1'b1);
    check_quiet("t3", 3);
    model_fill_blank();
    read_sweep(0, 255);

    // Test 4: clear and write requested together; clear wins, write follows.
    clr_req = 1'b1;
    applyStimulus(8'h05, 7'h58);
    @(negedge clk);
    checkOutput("t4_busy_start", {31'd0, busy}, 32'd1);
    checkOutput("t4_no_ack_start", {31'd0, wr_ack}, 32'd0);
    wait_clear("t4", 1'b0);
    @(negedge clk);
    checkOutput("t4_ack_after_clear", {31'd0, wr_ack}, 32'd1);
    wr_req = 1'b0;
    model[8'h05] = 7'h58;
    @(negedge clk);
    read_sweep(0, 255);

    // Test 5: same-address read and write returns the old data first.
    char_xy = 8'h30;
    applyStimulus(8'h30, 7'h5A);
    exp_q.push_back(model[8'h30]);
    @(negedge clk);
    checkOutput("t5_read_first", {25'd0, char_code}, {25'd0, exp_q.pop_front()});
    checkOutput("t5_ack", {31'd0, wr_ack}, 32'd1);
    wr_req = 1'b0;
    model[8'h30] = 7'h5A;
    exp_q.push_back(model[8'h30]);
    @(negedge clk);
    checkOutput("t5_read_new", {25'd0, char_code}, {25'd0, exp_q.pop_front()});

    // Test 6: reset asserted at cnt=100 during CLEAR.
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (100) @(negedge clk);
    checkOutput("t6_busy_mid", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("t6_rst_char_code", {25'd0, char_code}, 32'd0);
    checkOutput("t6_rst_busy", {31'd0, busy}, 32'd1);
    checkOutput("t6_rst_wr_ack", {31'd0, wr_ack}, 32'd0);
    checkOutput("t6_rst_clr_done", {31'd0, clr_done}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_clear("t6", 1'b0);
    check_quiet("t6", 5);
    model_fill_blank();
    read_sweep(0, 255);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
